// File: rtl/ysyx_23060124_icache_ctrl.sv
// Miss/refill sequencer for the direct-mapped IFU instruction cache.
// Serves one fetch at a time: probe the icache, refill misses over AXI4-Lite, answer the IFU.
module ysyx_23060124_icache_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] UC_BASE    = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] UC_MASK    = 32'hF000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [DATA_WIDTH-1:0] ifu_rsp_data,
  output logic                  ifu_rsp_err,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_req,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_data,
  output logic                  cache_fill_valid,
  output logic [DATA_WIDTH-1:0] cache_fill_data,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_AR     = 3'd2,
    S_R      = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_cache_req;
  logic                  r_arvalid;
  logic                  r_rready;
  logic [31:0]           r_hit_cnt;
  logic [31:0]           r_miss_cnt;

  logic w_uncacheable;
  logic w_fill;

  assign w_uncacheable = ((r_addr & UC_MASK) == UC_BASE);
  // The fill must coincide with the R beat so the icache writes while cache_addr still holds the fetch.
  assign w_fill = (r_state == S_R) && rvalid && (rresp == 2'b00) && !w_uncacheable;

  assign ifu_req_ready    = r_req_ready;
  assign ifu_rsp_valid    = r_rsp_valid;
  assign ifu_rsp_data     = r_data;
  assign ifu_rsp_err      = r_err;
  assign cache_addr       = r_addr;
  assign cache_req        = r_cache_req;
  assign cache_fill_valid = w_fill;
  assign cache_fill_data  = rdata;
  assign arvalid          = r_arvalid;
  assign araddr           = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign rready           = r_rready;
  assign hit_cnt          = r_hit_cnt;
  assign miss_cnt         = r_miss_cnt;

  // Fetch sequencer with registered handshake outputs and perf counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_data      <= {DATA_WIDTH{1'b0}};
      r_err       <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_cache_req <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_hit_cnt   <= 32'd0;
      r_miss_cnt  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ifu_req_valid) begin
            r_addr      <= ifu_addr;
            r_req_ready <= 1'b0;
            r_cache_req <= 1'b1;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_cache_req <= 1'b0;
          // Uncacheable fetches bypass the probe result and leave the counters alone.
          if (w_uncacheable) begin
            r_arvalid <= 1'b1;
            r_state   <= S_AR;
          end else if (cache_hit) begin
            r_data      <= cache_data;
            r_err       <= 1'b0;
            r_hit_cnt   <= r_hit_cnt + 32'd1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
            r_arvalid  <= 1'b1;
            r_state    <= S_AR;
          end
        end
        S_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            r_rready    <= 1'b0;
            r_data      <= rdata;
            r_err       <= (rresp != 2'b00);
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (ifu_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_cache_req <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_icache_ctrl.sv
// Directed bench for the icache miss/refill sequencer: stimulus pushes expected responses,
// a monitor pops them on each IFU response handshake; fills are counted independently.
module tb_ysyx_23060124_icache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic [31:0] cache_addr;
  logic        cache_req;
  logic        cache_hit;
  logic [31:0] cache_data;
  logic        cache_fill_valid;
  logic [31:0] cache_fill_data;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  int          fill_cnt = 0;
  logic [31:0] fill_data_last = 32'd0;
  logic [31:0] fill_addr_last = 32'd0;

  ysyx_23060124_icache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .cache_addr(cache_addr), .cache_req(cache_req), .cache_hit(cache_hit), .cache_data(cache_data),
    .cache_fill_valid(cache_fill_valid), .cache_fill_data(cache_fill_data),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample one time unit before each rising edge: what is seen here is what the DUT commits.
  always @(negedge clk) begin
    #4;
    if (cache_fill_valid === 1'b1) begin
      fill_cnt++;
      fill_data_last = cache_fill_data;
      fill_addr_last = cache_addr;
    end
    if (ifu_rsp_valid === 1'b1 && ifu_rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("sb_rsp_data", ifu_rsp_data, e[31:0]);
        chk("sb_rsp_err", {31'd0, ifu_rsp_err}, {31'd0, e[32]});
      end
    end
  end

  // Issue a fetch; returns at the falling edge of the LOOKUP cycle.
  task automatic fetch(input logic [31:0] a);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, ifu_req_ready}, 32'd1);
    ifu_req_valid = 1'b1;
    ifu_addr      = a;
    @(negedge clk);
    ifu_req_valid = 1'b0;
  endtask

  task automatic ar_phase(input int ar_wait, input logic [31:0] exp_araddr);
    int n;
    n = 0;
    while (arvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arvalid_seen", {31'd0, arvalid}, 32'd1);
    for (int i = 0; i < ar_wait; i++) begin
      chk("araddr_hold", araddr, exp_araddr);
      chk("arvalid_hold", {31'd0, arvalid}, 32'd1);
      @(negedge clk);
    end
    chk("araddr", araddr, exp_araddr);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("arvalid_drop", {31'd0, arvalid}, 32'd0);
  endtask

  task automatic r_phase(input int r_wait, input logic [31:0] d, input logic [1:0] resp,
                         input logic exp_fill);
    for (int i = 0; i < r_wait; i++) @(negedge clk);
    chk("rready", {31'd0, rready}, 32'd1);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = resp;
    #1;
    chk("fill_valid", {31'd0, cache_fill_valid}, {31'd0, exp_fill});
    @(negedge clk);
    rvalid = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (ifu_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'd0, ifu_req_ready}, 32'd1);
  endtask

  initial begin
    int f0;
    rst_n = 1'b0; ifu_req_valid = 1'b0; ifu_addr = 32'd0; ifu_rsp_ready = 1'b1;
    cache_hit = 1'b0; cache_data = 32'd0; arready = 1'b0; rvalid = 1'b0;
    rdata = 32'd0; rresp = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, ifu_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, ifu_rsp_valid}, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_cache_req", {31'd0, cache_req}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_rsp_data", ifu_rsp_data, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);

    // 1: hit, response in cycle 2, no bus traffic
    cache_hit = 1'b1; cache_data = 32'h0000_0413;
    exp_q.push_back({1'b0, 32'h0000_0413});
    fetch(32'h8000_0000);
    chk("t1_cache_req", {31'd0, cache_req}, 32'd1);
    chk("t1_cache_addr", cache_addr, 32'h8000_0000);
    chk("t1_rsp_c1", {31'd0, ifu_rsp_valid}, 32'd0);
    @(negedge clk);
    chk("t1_rsp_c2", {31'd0, ifu_rsp_valid}, 32'd1);
    chk("t1_no_ar", {31'd0, arvalid}, 32'd0);
    @(negedge clk);
    chk("t1_req_ready", {31'd0, ifu_req_ready}, 32'd1);
    chk("t1_hit_cnt", hit_cnt, 32'd1);
    chk("t1_fills", fill_cnt, 32'd0);

    // 2: miss, arready delayed 3 cycles, OKAY refill
    cache_hit = 1'b0; cache_data = 32'hFFFF_FFFF;
    exp_q.push_back({1'b0, 32'h0010_0073});
    fetch(32'h8000_0004);
    ar_phase(3, 32'h8000_0004);
    r_phase(0, 32'h0010_0073, 2'b00, 1'b1);
    wait_idle();
    chk("t2_miss_cnt", miss_cnt, 32'd1);
    chk("t2_hit_cnt", hit_cnt, 32'd1);
    chk("t2_fills", fill_cnt, 32'd1);
    chk("t2_fill_data", fill_data_last, 32'h0010_0073);
    chk("t2_fill_addr", fill_addr_last, 32'h8000_0004);

    // 3: miss with SLVERR, unaligned fetch address word-aligned on AR
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    fetch(32'h8000_000A);
    ar_phase(0, 32'h8000_0008);
    r_phase(2, 32'hDEAD_BEEF, 2'b10, 1'b0);
    wait_idle();
    chk("t3_miss_cnt", miss_cnt, 32'd2);
    chk("t3_fills", fill_cnt, 32'd1);

    // 4: uncacheable with hit asserted, minimum bus latency -> rsp in cycle 4
    cache_hit = 1'b1; cache_data = 32'h1234_5678;
    exp_q.push_back({1'b0, 32'hCAFE_0001});
    fetch(32'h1000_0000);
    ar_phase(0, 32'h1000_0000);
    r_phase(0, 32'hCAFE_0001, 2'b00, 1'b0);
    chk("t4_rsp_c4", {31'd0, ifu_rsp_valid}, 32'd1);
    wait_idle();
    chk("t4_hit_cnt", hit_cnt, 32'd1);
    chk("t4_miss_cnt", miss_cnt, 32'd2);
    chk("t4_fills", fill_cnt, 32'd1);

    // 5: IFU stalls the response for 5 cycles while the cache changes underneath
    cache_hit = 1'b1; cache_data = 32'h0000_0513;
    ifu_rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h0000_0513});
    fetch(32'h8000_0010);
    @(negedge clk);
    cache_data = 32'hAAAA_5555;
    for (int i = 0; i < 5; i++) begin
      chk("t5_rsp_valid", {31'd0, ifu_rsp_valid}, 32'd1);
      chk("t5_rsp_data", ifu_rsp_data, 32'h0000_0513);
      chk("t5_req_ready", {31'd0, ifu_req_ready}, 32'd0);
      @(negedge clk);
    end
    ifu_rsp_ready = 1'b1;
    wait_idle();
    chk("t5_hit_cnt", hit_cnt, 32'd2);

    // 6: asynchronous reset while waiting for R
    cache_hit = 1'b0;
    f0 = fill_cnt;
    fetch(32'h8000_0020);
    ar_phase(0, 32'h8000_0020);
    chk("t6_in_r", {31'd0, rready}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rready", {31'd0, rready}, 32'd0);
    chk("t6_arvalid", {31'd0, arvalid}, 32'd0);
    chk("t6_rsp_valid", {31'd0, ifu_rsp_valid}, 32'd0);
    chk("t6_req_ready", {31'd0, ifu_req_ready}, 32'd1);
    chk("t6_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h0BAD_0BAD;
    #1;
    chk("t6_no_fill", {31'd0, cache_fill_valid}, 32'd0);
    @(negedge clk);
    rvalid = 1'b0;
    rst_n = 1'b1;
    cache_hit = 1'b1; cache_data = 32'h0000_0093;
    exp_q.push_back({1'b0, 32'h0000_0093});
    fetch(32'h8000_0024);
    @(negedge clk);
    chk("t6_post_rsp", {31'd0, ifu_rsp_valid}, 32'd1);
    wait_idle();
    chk("t6_hit_cnt", hit_cnt, 32'd1);
    chk("t6_fills", fill_cnt, f0);

    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
